// File: rtl/fp_mult_pkg.sv
// Types and constants shared by the FP32 multiplier and its two-requester scheduler.
package fp_mult_pkg;

    localparam int FP_W           = 32;
    localparam int STATUS_W       = 8;
    localparam int STATUS_INEXACT = 0;
    localparam int RET_W          = FP_W + STATUS_W;

    typedef logic req_id_t;

    typedef enum logic [2:0] {
        RND_NEAREST_EVEN = 3'd0,
        RND_TOWARD_ZERO  = 3'd1,
        RND_DOWN         = 3'd2,
        RND_UP           = 3'd3,
        RND_NEAREST_MAX  = 3'd4
    } round_values;

    typedef struct packed {
        logic [FP_W-1:0]     z;
        logic [STATUS_W-1:0] status;
    } ret_t;

endpackage

// File: rtl/fp_ret_fifo.sv
// Return buffer: synchronous FIFO; a push is readable one cycle later, with no bypass.
// Backpressure: a push when full and a pop when empty are ignored; the caller must honour o_full/o_empty.
module fp_ret_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dat   = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/fp_mult_sched.sv
// Shares one fixed-latency FP32 multiplier between two requesters; issue registered 1 cycle after handshake.
// Backpressure: inK_ready drops when inflight+buffered reaches DEPTH, so every return has a reserved slot.
module fp_mult_sched
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in0_valid,
    output logic                in0_ready,
    input  logic [FP_W-1:0]     in0_a,
    input  logic [FP_W-1:0]     in0_b,
    input  logic                in1_valid,
    output logic                in1_ready,
    input  logic [FP_W-1:0]     in1_a,
    input  logic [FP_W-1:0]     in1_b,
    output logic                mul_issue,
    output logic [FP_W-1:0]     mul_a,
    output logic [FP_W-1:0]     mul_b,
    output req_id_t             mul_tag,
    input  logic                mul_ret,
    input  req_id_t             mul_ret_tag,
    input  logic [FP_W-1:0]     mul_z,
    input  logic [STATUS_W-1:0] mul_status,
    output logic                out0_valid,
    input  logic                out0_ready,
    output logic [FP_W-1:0]     out0_z,
    output logic [STATUS_W-1:0] out0_status,
    output logic                out1_valid,
    input  logic                out1_ready,
    output logic [FP_W-1:0]     out1_z,
    output logic [STATUS_W-1:0] out1_status,
    output logic                err
);

    logic                r_ptr;
    logic [CW-1:0]       r_inflight [2];
    logic                r_mul_issue;
    logic [FP_W-1:0]     r_mul_a;
    logic [FP_W-1:0]     r_mul_b;
    req_id_t             r_mul_tag;
    logic                r_err;

    logic [1:0]          w_in_valid;
    logic [1:0]          w_out_ready;
    logic [1:0]          w_credit;
    logic [1:0]          w_elig;
    logic [1:0]          w_grant;
    logic [1:0]          w_ret;
    logic [1:0]          w_dec;
    logic [1:0]          w_push;
    logic [1:0]          w_pop;
    logic [1:0]          w_full;
    logic [1:0]          w_empty;
    logic [1:0]          w_ret_err;
    logic [CW-1:0]       w_count [2];
    logic [CW:0]         w_occ   [2];
    ret_t                w_head  [2];
    ret_t                w_ret_dat;

    assign w_in_valid  = {in1_valid, in0_valid};
    assign w_out_ready = {out1_ready, out0_ready};
    assign w_ret_dat   = '{z: mul_z, status: mul_status};

    // Credit uses registered state only, so a same-cycle pop frees its slot next cycle.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_occ[k]     = {1'b0, r_inflight[k]} + {1'b0, w_count[k]};
            w_credit[k]  = (w_occ[k] < (CW+1)'(DEPTH));
            w_elig[k]    = w_in_valid[k] & w_credit[k];
            w_ret[k]     = mul_ret & (mul_ret_tag == req_id_t'(k));
            w_dec[k]     = w_ret[k] & (r_inflight[k] != '0);
            w_push[k]    = w_dec[k] & ~w_full[k];
            w_ret_err[k] = w_ret[k] & ((r_inflight[k] == '0) | w_full[k]);
            w_pop[k]     = ~w_empty[k] & w_out_ready[k];
        end
        w_grant[0] = w_elig[0] & (~w_elig[1] | ~r_ptr);
        w_grant[1] = w_elig[1] & (~w_elig[0] |  r_ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 1'b0;
            r_inflight  <= '{default: '0};
            r_mul_issue <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_tag   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mul_issue <= |w_grant;
            if (|w_grant) begin
                r_mul_a   <= w_grant[1] ? in1_a : in0_a;
                r_mul_b   <= w_grant[1] ? in1_b : in0_b;
                r_mul_tag <= req_id_t'(w_grant[1]);
                r_ptr     <= w_grant[0];
            end
            for (int k = 0; k < 2; k++) begin
                case ({w_grant[k], w_dec[k]})
                    2'b10:   r_inflight[k] <= r_inflight[k] + 1'b1;
                    2'b01:   r_inflight[k] <= r_inflight[k] - 1'b1;
                    default: r_inflight[k] <= r_inflight[k];
                endcase
            end
            r_err <= r_err | (|w_ret_err);
        end
    end

    fp_ret_fifo #(.DEPTH(DEPTH), .W(RET_W), .CW(CW)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[0]),
        .i_dat   (w_ret_dat),
        .i_pop   (w_pop[0]),
        .o_dat   (w_head[0]),
        .o_full  (w_full[0]),
        .o_empty (w_empty[0]),
        .o_count (w_count[0])
    );

    fp_ret_fifo #(.DEPTH(DEPTH), .W(RET_W), .CW(CW)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[1]),
        .i_dat   (w_ret_dat),
        .i_pop   (w_pop[1]),
        .o_dat   (w_head[1]),
        .o_full  (w_full[1]),
        .o_empty (w_empty[1]),
        .o_count (w_count[1])
    );

    assign in0_ready   = w_grant[0];
    assign in1_ready   = w_grant[1];
    assign mul_issue   = r_mul_issue;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_tag     = r_mul_tag;
    assign out0_valid  = ~w_empty[0];
    assign out0_z      = w_head[0].z;
    assign out0_status = w_head[0].status;
    assign out1_valid  = ~w_empty[1];
    assign out1_z      = w_head[1].z;
    assign out1_status = w_head[1].status;
    assign err         = r_err;

endmodule

// File: tb/tb_fp_mult_sched.sv
// Bench for fp_mult_sched: fixed-latency multiplier stand-in, request/response scoreboard, directed scenarios.
module tb_fp_mult_sched;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in0_ready, in1_valid, in1_ready;
    logic [31:0] in0_a, in0_b, in1_a, in1_b;
    logic        mul_issue, mul_tag, mul_ret, mul_ret_tag;
    logic [31:0] mul_a, mul_b, mul_z;
    logic [7:0]  mul_status;
    logic        out0_valid, out0_ready, out1_valid, out1_ready;
    logic [31:0] out0_z, out1_z;
    logic [7:0]  out0_status, out1_status;
    logic        err;

    logic        inj_ret = 1'b0;
    logic        inj_tag = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_mult_sched #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_a(in0_a), .in0_b(in0_b),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_a(in1_a), .in1_b(in1_b),
        .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b), .mul_tag(mul_tag),
        .mul_ret(mul_ret), .mul_ret_tag(mul_ret_tag), .mul_z(mul_z), .mul_status(mul_status),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_z(out0_z), .out0_status(out0_status),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_z(out1_z), .out1_status(out1_status),
        .err(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in product table: two exact FP32 cases, otherwise an arbitrary tagged pattern.
    function automatic logic [39:0] prod(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return {32'h4040_0000, 8'h00};
        if (a == 32'h3F80_0001 && b == 32'h3F80_0001) return {32'h3F80_0002, 8'h01};
        return {a + b, a[7:0] ^ b[7:0]};
    endfunction

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        logic        tag;
    } mop_t;

    // Multiplier stand-in: in-order, fixed latency, shares rst with the scheduler.
    initial begin : mult
        mop_t        mq[$];
        mop_t        m;
        logic [39:0] r;
        int          c;
        c = 0;
        mul_ret = 0; mul_ret_tag = 0; mul_z = 0; mul_status = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            mul_ret = 0; mul_ret_tag = 0; mul_z = 0; mul_status = 0;
            if (rst) begin
                mq.delete();
            end else begin
                if (mul_issue) begin
                    m.due = c + LAT; m.a = mul_a; m.b = mul_b; m.tag = mul_tag;
                    mq.push_back(m);
                end
                if (mq.size() > 0 && mq[0].due == c) begin
                    m = mq.pop_front();
                    r = prod(m.a, m.b);
                    mul_ret = 1; mul_ret_tag = m.tag; mul_z = r[39:8]; mul_status = r[7:0];
                end
                if (inj_ret) begin
                    mul_ret = 1; mul_ret_tag = inj_tag; mul_z = 32'hDEAD_BEEF; mul_status = 8'hFF;
                end
            end
        end
    end

    // Scoreboard: per requester, every accepted request stays outstanding until its result is popped.
    logic        m_ptr, m_iss, m_tag, m_err;
    logic [31:0] m_a, m_b;
    int          m_outst [2];
    int          m_avail [2];
    logic [39:0] m_q0[$];
    logic [39:0] m_q1[$];

    initial begin : mon
        bit e0, e1, g0, g1, v0, v1;
        int infl, av;
        m_ptr = 0; m_iss = 0; m_tag = 0; m_err = 0; m_a = 0; m_b = 0;
        m_outst = '{0, 0}; m_avail = '{0, 0};
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_issue", mul_issue, 0);
                chk("rst_out0_valid", out0_valid, 0);
                chk("rst_out1_valid", out1_valid, 0);
                chk("rst_err", err, 0);
                m_ptr = 0; m_iss = 0; m_tag = 0; m_err = 0; m_a = 0; m_b = 0;
                m_outst = '{0, 0}; m_avail = '{0, 0};
                m_q0.delete(); m_q1.delete();
            end else begin
                e0 = in0_valid && (m_outst[0] < DEPTH);
                e1 = in1_valid && (m_outst[1] < DEPTH);
                g0 = e0 && (!e1 || !m_ptr);
                g1 = e1 && (!e0 || m_ptr);
                v0 = m_avail[0] > 0;
                v1 = m_avail[1] > 0;
                chk("in0_ready", in0_ready, g0);
                chk("in1_ready", in1_ready, g1);
                chk("mul_issue", mul_issue, m_iss);
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
                chk("mul_tag", mul_tag, m_tag);
                chk("err", err, m_err);
                chk("out0_valid", out0_valid, v0);
                chk("out1_valid", out1_valid, v1);
                if (v0) chk("out0_data", {out0_z, out0_status}, m_q0[0]);
                if (v1) chk("out1_data", {out1_z, out1_status}, m_q1[0]);
                if (mul_ret) begin
                    infl = m_outst[mul_ret_tag] - m_avail[mul_ret_tag];
                    av   = m_avail[mul_ret_tag];
                    if (infl == 0 || av == DEPTH) m_err = 1;
                    else m_avail[mul_ret_tag]++;
                end
                if (v0 && out0_ready) begin void'(m_q0.pop_front()); m_outst[0]--; m_avail[0]--; end
                if (v1 && out1_ready) begin void'(m_q1.pop_front()); m_outst[1]--; m_avail[1]--; end
                m_iss = g0 || g1;
                if (g0) begin
                    m_a = in0_a; m_b = in0_b; m_tag = 0; m_ptr = 1;
                    m_q0.push_back(prod(in0_a, in0_b)); m_outst[0]++;
                end else if (g1) begin
                    m_a = in1_a; m_b = in1_b; m_tag = 1; m_ptr = 0;
                    m_q1.push_back(prod(in1_a, in1_b)); m_outst[1]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int t_ret, t_v, hs0, hs1, tri_cnt;
        rst = 1; in0_valid = 0; in1_valid = 0; in0_a = 0; in0_b = 0; in1_a = 0; in1_b = 0;
        out0_ready = 1; out1_ready = 1;
        repeat (3) @(negedge clk);
        chk("lit_rst_issue", mul_issue, 0);
        tick(); rst = 0;

        // Requester 0: 1.5 * 2.0 = 3.0
        in0_valid = 1; in0_a = 32'h3FC0_0000; in0_b = 32'h4000_0000;
        @(negedge clk); chk("dp0_ready", in0_ready, 1);
        tick(); in0_valid = 0;
        t_ret = -1; t_v = -1;
        for (int i = 0; i < 20 && t_v < 0; i++) begin
            @(negedge clk);
            if (mul_ret && !mul_ret_tag) t_ret = i;
            if (out0_valid) begin
                t_v = i;
                chk("dp0_z", out0_z, 32'h4040_0000);
                chk("dp0_status", out0_status, 8'h00);
            end
        end
        chk("dp0_seen", t_v >= 0, 1);
        chk("dp0_ret_to_valid", t_v - t_ret, 1);

        // Requester 1: inexact product, status passes through
        tick(); in1_valid = 1; in1_a = 32'h3F80_0001; in1_b = 32'h3F80_0001;
        @(negedge clk); chk("dp1_ready", in1_ready, 1);
        tick(); in1_valid = 0;
        t_ret = -1; t_v = -1;
        for (int i = 0; i < 20 && t_v < 0; i++) begin
            @(negedge clk);
            if (mul_ret && mul_ret_tag) t_ret = i;
            if (out1_valid) begin
                t_v = i;
                chk("dp1_z", out1_z, 32'h3F80_0002);
                chk("dp1_status", out1_status, 8'h01);
            end
        end
        chk("dp1_seen", t_v >= 0, 1);
        chk("dp1_ret_to_valid", t_v - t_ret, 1);

        // Fairness: both requesting every cycle
        tick(); in0_valid = 1; in1_valid = 1;
        for (int i = 0; i < 12; i++) begin
            in0_a = 32'h100 + i; in0_b = 32'h7; in1_a = 32'h200 + i; in1_b = 32'h9;
            @(negedge clk);
            if (i >= 1) begin
                chk("fair_issue", mul_issue, 1);
                chk("fair_tag", mul_tag, (i - 1) % 2);
            end
            tick();
        end
        in0_valid = 0; in1_valid = 0;
        repeat (12) tick();

        // Backpressure on requester 0
        out0_ready = 0; in0_valid = 1; in1_valid = 1; hs0 = 0; hs1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hs0 += int'(in0_valid && in0_ready);
            hs1 += int'(in1_valid && in1_ready);
            tick();
        end
        @(negedge clk);
        chk("bp_hs0", hs0, 4);
        chk("bp_in0_stalled", in0_ready, 0);
        chk("bp_in1_progress", hs1 >= 8, 1);
        tick(); out0_ready = 1;
        @(negedge clk);
        chk("bp_pop_valid", out0_valid, 1);
        chk("bp_pop_no_credit_yet", in0_ready, 0);
        tick(); out0_ready = 0;
        @(negedge clk);
        chk("bp_credit_after_pop", in0_ready, 1);
        hs0 = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); @(negedge clk);
            hs0 += int'(in0_valid && in0_ready);
        end
        chk("bp_only_one_extra", hs0, 0);
        tick(); in0_valid = 0; in1_valid = 0; out0_ready = 1;
        repeat (15) tick();

        // Handshake, return and pop on requester 0 in one cycle
        in0_valid = 1; tri_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            in0_a = 32'h300 + i; in0_b = 32'h1;
            @(negedge clk);
            if (in0_valid && in0_ready && mul_ret && !mul_ret_tag && out0_valid && out0_ready)
                tri_cnt++;
            tick();
        end
        chk("sim_triple_seen", tri_cnt > 0, 1);
        chk("sim_no_err", err, 0);
        in0_valid = 0;
        repeat (12) tick();

        // Spurious return for requester 1
        @(negedge clk); inj_tag = 1; inj_ret = 1;
        @(negedge clk); inj_ret = 0;
        @(negedge clk);
        chk("perr_set", err, 1);
        chk("perr_no_out1", out1_valid, 0);
        repeat (5) @(negedge clk);
        chk("perr_sticky", err, 1);
        chk("perr_no_out1_later", out1_valid, 0);

        // Reset with work in flight
        tick(); in0_valid = 1; in1_valid = 1;
        repeat (3) tick();
        rst = 1;
        @(negedge clk);
        chk("mid_rst_issue", mul_issue, 0);
        chk("mid_rst_err", err, 0);
        tick(); tick(); rst = 0;
        @(negedge clk);
        chk("post_rst_grant0", in0_ready, 1);
        chk("post_rst_no_grant1", in1_ready, 0);
        tick(); in0_valid = 0; in1_valid = 0;
        repeat (10) tick();
        @(negedge clk);
        chk("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
